// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one retimed FP multiplier among NUM_REQ requesters.
// Credits bound in-flight plus stored results, so the pipeline never stalls.

package fp_mul_arbiter_pkg;
    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    function automatic int unsigned exp_bits(fp_format_e f);
        case (f)
            FP32:    return 8;
            FP64:    return 11;
            FP16:    return 5;
            FP8:     return 5;
            FP16ALT: return 8;
            default: return 8;
        endcase
    endfunction

    function automatic int unsigned man_bits(fp_format_e f);
        case (f)
            FP32:    return 23;
            FP64:    return 52;
            FP16:    return 10;
            FP8:     return 2;
            FP16ALT: return 7;
            default: return 23;
        endcase
    endfunction

    function automatic int unsigned fp_width(fp_format_e f);
        return 1 + exp_bits(f) + man_bits(f);
    endfunction
endpackage

// Combinational IEEE multiply with mixed formats, RNE rounding, subnormal in/out.
module fp_mul #(
    parameter int unsigned EA = 5,
    parameter int unsigned MA = 10,
    parameter int unsigned EB = 5,
    parameter int unsigned MB = 10,
    parameter int unsigned EO = 8,
    parameter int unsigned MO = 23
) (
    input  logic [EA+MA:0] a_i,
    input  logic [EB+MB:0] b_i,
    output logic [EO+MO:0] r_o
);
    localparam int unsigned PW = MA + MB + 2;
    localparam int unsigned XW = PW + MO + 3;
    localparam int EW = 16;
    localparam int BIAS_A = (1 << (EA - 1)) - 1;
    localparam int BIAS_B = (1 << (EB - 1)) - 1;
    localparam int BIAS_O = (1 << (EO - 1)) - 1;
    localparam int EMAX = (1 << EO) - 1;
    localparam logic signed [EW-1:0] EOFF = EW'(BIAS_O - BIAS_A - BIAS_B - int'(MA) - int'(MB));

    logic sa, sb, so;
    logic [EA-1:0] xa;
    logic [MA-1:0] fa;
    logic [EB-1:0] xb;
    logic [MB-1:0] fb;
    logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic [PW-1:0] prod;

    assign {sa, xa, fa} = a_i;
    assign {sb, xb, fb} = b_i;
    assign so     = sa ^ sb;
    assign a_zero = (xa == '0) && (fa == '0);
    assign b_zero = (xb == '0) && (fb == '0);
    assign a_inf  = (&xa) && (fa == '0);
    assign b_inf  = (&xb) && (fb == '0);
    assign a_nan  = (&xa) && (fa != '0);
    assign b_nan  = (&xb) && (fb != '0);
    assign prod   = PW'({|xa, fa}) * PW'({|xb, fb});

    logic [EW-1:0] lead;
    logic signed [EW-1:0] exp_c, sh;
    logic [XW-1:0] ext;
    logic sticky, guard, rnd;
    logic [EO-1:0] exp_f;
    logic [MO-1:0] frac;
    logic [EO+MO-1:0] body;

    always_comb begin
        lead = '0;
        for (int i = 0; i < int'(PW); i++)
            if (prod[i]) lead = EW'(i);
        // Biased exponent of the leading one; a zero exponent field counts as 1.
        exp_c  = $signed(EW'(xa) + EW'(xa == '0) + EW'(xb) + EW'(xb == '0) + lead) + EOFF;
        ext    = XW'(prod) << (XW - 32'd1 - 32'(lead));
        sh     = '0;
        sticky = 1'b0;
        exp_f  = exp_c[EO-1:0];
        if (exp_c < 1) begin
            sh    = EW'(1) - exp_c;
            exp_f = '0;
            if (sh >= $signed(EW'(XW))) begin
                sticky = |ext;
                ext    = '0;
            end else begin
                sticky = |(ext & ~({XW{1'b1}} << sh));
                ext    = ext >> sh;
            end
        end
        frac   = ext[XW-2 -: MO];
        guard  = ext[XW-2-MO];
        sticky = sticky | (|ext[XW-3-MO:0]);
        rnd    = guard & (sticky | frac[0]);
        // Rounding carry may ripple into the exponent, including up to infinity.
        body   = {exp_f, frac} + (EO+MO)'(rnd);

        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
            r_o = {1'b0, {EO{1'b1}}, MO'(1) << (MO - 1)};
        else if (a_inf || b_inf)
            r_o = {so, {EO{1'b1}}, {MO{1'b0}}};
        else if (a_zero || b_zero)
            r_o = {so, {(EO+MO){1'b0}}};
        else if (exp_c >= EMAX)
            r_o = {so, {EO{1'b1}}, {MO{1'b0}}};
        else
            r_o = {so, body};
    end
endmodule

module fp_mul_arbiter
    import fp_mul_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter fp_format_e  FP_FMT_A   = fp_format_e'(2),
    parameter fp_format_e  FP_FMT_B   = fp_format_e'(2),
    parameter fp_format_e  FP_FMT_OUT = fp_format_e'(0),
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned WIDTH_A   = fp_width(FP_FMT_A),
    localparam int unsigned WIDTH_B   = fp_width(FP_FMT_B),
    localparam int unsigned WIDTH_OUT = fp_width(FP_FMT_OUT),
    localparam int unsigned ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    input  logic [NUM_REQ*WIDTH_A-1:0]   req_a_i,
    input  logic [NUM_REQ*WIDTH_B-1:0]   req_b_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [WIDTH_OUT-1:0]         rsp_result_o,
    output logic [ID_W-1:0]              rsp_id_o,
    output logic                         busy_o
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [ID_W-1:0]  prio_q, prio_d, gnt_idx, scan_idx;
    logic             gnt_vld, accept, push, pop;
    logic [CNT_W-1:0] used_q, used_d;

    // Scan from the far end so the requester nearest to prio wins.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            scan_idx = ID_W'((int'(prio_q) + k) % int'(NUM_REQ));
            if (req_valid_i[scan_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan_idx;
            end
        end
    end

    assign accept = gnt_vld && (used_q < CNT_W'(FIFO_DEPTH)) && !rst_i;
    assign busy_o = (used_q != '0);

    always_comb begin
        req_ready_o = '0;
        if (accept) req_ready_o[gnt_idx] = 1'b1;
    end

    assign prio_d = !accept ? prio_q :
                    (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        used_d = used_q;
        if (accept && !pop)      used_d = used_q + 1'b1;
        else if (!accept && pop) used_d = used_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= '0;
            used_q <= '0;
        end else begin
            prio_q <= prio_d;
            used_q <= used_d;
        end
    end

    logic [LATENCY:1]     vld_q;
    logic [WIDTH_A-1:0]   a_q;
    logic [WIDTH_B-1:0]   b_q;
    logic [ID_W-1:0]      id_q [LATENCY];
    logic [WIDTH_OUT-1:0] mul_res, push_res;
    logic [ID_W-1:0]      push_id;

    always_ff @(posedge clk_i) begin
        if (rst_i) vld_q <= '0;
        else       vld_q <= LATENCY'({vld_q, accept});
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            a_q <= req_a_i[gnt_idx*WIDTH_A +: WIDTH_A];
            b_q <= req_b_i[gnt_idx*WIDTH_B +: WIDTH_B];
        end
        id_q[0] <= gnt_idx;
        for (int k = 1; k < int'(LATENCY); k++) id_q[k] <= id_q[k-1];
    end

    fp_mul #(
        .EA (exp_bits(FP_FMT_A)),   .MA (man_bits(FP_FMT_A)),
        .EB (exp_bits(FP_FMT_B)),   .MB (man_bits(FP_FMT_B)),
        .EO (exp_bits(FP_FMT_OUT)), .MO (man_bits(FP_FMT_OUT))
    ) u_fp_mul (
        .a_i (a_q),
        .b_i (b_q),
        .r_o (mul_res)
    );

    // Stage 1 holds operands; the product is registered through stages 2..LATENCY.
    if (LATENCY == 1) begin : g_lat1
        assign push_res = mul_res;
    end else begin : g_latn
        logic [WIDTH_OUT-1:0] res_q [LATENCY-1];
        always_ff @(posedge clk_i) begin
            res_q[0] <= mul_res;
            for (int k = 1; k < int'(LATENCY) - 1; k++) res_q[k] <= res_q[k-1];
        end
        assign push_res = res_q[LATENCY-2];
    end

    assign push    = vld_q[LATENCY];
    assign push_id = id_q[LATENCY-1];

    logic [WIDTH_OUT+ID_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_q, rd_q;
    logic [CNT_W-1:0]          cnt_q;

    assign rsp_valid_o = (cnt_q != '0);
    assign pop         = rsp_valid_o && rsp_ready_i;
    assign {rsp_id_o, rsp_result_o} = rsp_valid_o ? mem_q[rd_q] : '0;

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q] <= {push_id, push_res};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= (wr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_q + 1'b1;
            if (pop)  rd_q <= (rd_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_q + 1'b1;
            cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    a_credit_balance: assert property (@(posedge clk_i) disable iff (rst_i)
        (int'(cnt_q) + $countones(vld_q)) == int'(used_q));
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter: timing, round-robin order, credits, specials, reset.
module tb_fp_mul_arbiter;
    localparam int NR = 4;
    localparam int WO = 32;
    localparam int IW = 2;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [NR-1:0]     req_valid_i = '0;
    logic [NR-1:0]     req_ready_o;
    logic [NR*16-1:0]  req_a_i = '0;
    logic [NR*16-1:0]  req_b_i = '0;
    logic              rsp_valid_o;
    logic              rsp_ready_i = 1'b0;
    logic [WO-1:0]     rsp_result_o;
    logic [IW-1:0]     rsp_id_o;
    logic              busy_o;

    int n_vec = 0;
    int n_err = 0;
    logic [IW+WO-1:0] rsp_q [$];

    logic [15:0] a_tab [4] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};
    logic [31:0] p_tab [4] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};
    logic [15:0] sa_tab [7] = '{16'h7C00, 16'hBC00, 16'h7C00, 16'h0001, 16'h7E00, 16'h8000, 16'hFC00};
    logic [15:0] sb_tab [7] = '{16'h0000, 16'h4000, 16'h3C00, 16'h3C00, 16'h3C00, 16'h4000, 16'h4000};
    logic [31:0] sp_tab [7] = '{32'h7FC00000, 32'hC0000000, 32'h7F800000, 32'h33800000,
                                32'h7FC00000, 32'h80000000, 32'hFF800000};

    fp_mul_arbiter dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_a_i      (req_a_i),
        .req_b_i      (req_b_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_result_o (rsp_result_o),
        .rsp_id_o     (rsp_id_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i)
        if (!rst_i && rsp_valid_o && rsp_ready_i) rsp_q.push_back({rsp_id_o, rsp_result_o});

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_op(input int r, input logic [15:0] a, input logic [15:0] b);
        req_a_i[r*16 +: 16] = a;
        req_b_i[r*16 +: 16] = b;
    endtask

    task automatic load_tab();
        for (int i = 0; i < NR; i++) set_op(i, a_tab[i], 16'h4000);
    endtask

    task automatic do_reset();
        rst_i = 1'b1; req_valid_i = '0; rsp_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        rsp_q.delete();
    endtask

    task automatic wait_rsp(input int n);
        for (int i = 0; i < 60 && rsp_q.size() < n; i++) @(negedge clk_i);
        chk("drain_count", 64'(rsp_q.size()), 64'(n));
    endtask

    task automatic chk_rsp(input string tag, input int k, input logic [IW-1:0] id, input logic [WO-1:0] res);
        logic [63:0] got;
        got = (k < rsp_q.size()) ? 64'(rsp_q[k]) : '1;
        chk(tag, got, 64'({id, res}));
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_ready", 64'(req_ready_o), 0);
        chk("rst_rvalid", 64'(rsp_valid_o), 0);
        chk("rst_result", 64'(rsp_result_o), 0);
        chk("rst_id", 64'(rsp_id_o), 0);
        chk("rst_busy", 64'(busy_o), 0);

        // Single op: accept at t, response visible at t+3, idle at t+4
        set_op(1, 16'h3C00, 16'h4000);
        req_valid_i = 4'b0010; rsp_ready_i = 1'b1; #1;
        chk("one_ready", 64'(req_ready_o), 64'h2);
        @(negedge clk_i); req_valid_i = '0;
        chk("one_busy", 64'(busy_o), 1);
        chk("one_v1", 64'(rsp_valid_o), 0);
        @(negedge clk_i); chk("one_v2", 64'(rsp_valid_o), 0);
        @(negedge clk_i);
        chk("one_v3", 64'(rsp_valid_o), 1);
        chk("one_res", 64'(rsp_result_o), 64'h40000000);
        chk("one_id", 64'(rsp_id_o), 1);
        @(negedge clk_i);
        chk("one_pop_v", 64'(rsp_valid_o), 0);
        chk("one_pop_busy", 64'(busy_o), 0);

        // Round-robin with all requesters valid
        do_reset(); load_tab();
        rsp_ready_i = 1'b1; req_valid_i = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1 chk($sformatf("rr_ready%0d", k), 64'(req_ready_o), 64'd1 << (k % 4));
            @(negedge clk_i);
        end
        req_valid_i = '0;
        wait_rsp(8);
        for (int k = 0; k < 8; k++)
            chk_rsp($sformatf("rr_rsp%0d", k), k, IW'(k % 4), p_tab[k % 4]);

        // Backpressure: credits stop accepts at FIFO_DEPTH
        do_reset(); load_tab();
        req_valid_i = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1 chk($sformatf("bp_ready%0d", k), 64'(req_ready_o), (k < 4) ? (64'd1 << k) : 64'd0);
            @(negedge clk_i);
        end
        chk("bp_full_v", 64'(rsp_valid_o), 1);
        chk("bp_full_id", 64'(rsp_id_o), 0);
        rsp_ready_i = 1'b1; #1;
        chk("bp_pop_nocomb", 64'(req_ready_o), 0);
        @(negedge clk_i); rsp_ready_i = 1'b0; #1;
        chk("bp_reaccept", 64'(req_ready_o), 64'h1);
        chk("bp_popped", 64'(rsp_q.size()), 1);
        @(negedge clk_i); #1;
        chk("bp_one_only", 64'(req_ready_o), 0);
        req_valid_i = '0;
        // Pop the head in the same cycle the re-accepted op lands in the FIFO
        @(negedge clk_i); rsp_ready_i = 1'b1;
        @(negedge clk_i); rsp_ready_i = 1'b0;
        chk("pp_v", 64'(rsp_valid_o), 1);
        chk("pp_head", 64'(rsp_id_o), 2);
        chk("pp_busy", 64'(busy_o), 1);
        rsp_ready_i = 1'b1;
        wait_rsp(5);
        chk_rsp("pp_rsp0", 0, 2'd0, p_tab[0]);
        chk_rsp("pp_rsp1", 1, 2'd1, p_tab[1]);
        chk_rsp("pp_rsp2", 2, 2'd2, p_tab[2]);
        chk_rsp("pp_rsp3", 3, 2'd3, p_tab[3]);
        chk_rsp("pp_rsp4", 4, 2'd0, p_tab[0]);
        @(negedge clk_i); chk("pp_idle", 64'(busy_o), 0);

        // Special values through requester 2
        do_reset();
        rsp_ready_i = 1'b1; req_valid_i = 4'b0100;
        for (int k = 0; k < 7; k++) begin
            set_op(2, sa_tab[k], sb_tab[k]);
            #1 chk($sformatf("sp_ready%0d", k), 64'(req_ready_o), 64'h4);
            @(negedge clk_i);
        end
        req_valid_i = '0;
        wait_rsp(7);
        for (int k = 0; k < 7; k++)
            chk_rsp($sformatf("sp_rsp%0d", k), k, 2'd2, sp_tab[k]);

        // Reset with two stored and two in flight, prio away from 0
        do_reset(); load_tab();
        rsp_ready_i = 1'b1; req_valid_i = 4'b0001;
        @(negedge clk_i); req_valid_i = '0;
        repeat (5) @(negedge clk_i);
        chk("rm_warm", 64'(rsp_q.size()), 1);
        rsp_ready_i = 1'b0; req_valid_i = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            #1 chk($sformatf("rm_ready%0d", k), 64'(req_ready_o), 64'd1 << ((k + 1) % 4));
            @(negedge clk_i);
        end
        chk("rm_pre_v", 64'(rsp_valid_o), 1);
        chk("rm_pre_id", 64'(rsp_id_o), 1);
        rst_i = 1'b1; #1;
        chk("rm_rst_gate", 64'(req_ready_o), 0);
        @(negedge clk_i);
        chk("rm_ready", 64'(req_ready_o), 0);
        chk("rm_rvalid", 64'(rsp_valid_o), 0);
        chk("rm_result", 64'(rsp_result_o), 0);
        chk("rm_id", 64'(rsp_id_o), 0);
        chk("rm_busy", 64'(busy_o), 0);
        rst_i = 1'b0; req_valid_i = '0; rsp_ready_i = 1'b1;
        repeat (6) @(negedge clk_i);
        chk("rm_no_stale", 64'(rsp_q.size()), 1);
        set_op(0, 16'h3C00, 16'h4400);
        req_valid_i = 4'b1001; #1;
        chk("rm_prio0", 64'(req_ready_o), 64'h1);
        @(negedge clk_i); req_valid_i = '0;
        wait_rsp(2);
        chk_rsp("rm_new", 1, 2'd0, 32'h40800000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
